// File: rtl/alu_6502_wide.sv
// Registered WIDTH-bit 6502-style ALU: single-cycle add/sub/shift/logic with a
// nibble-serial (optionally decimal) carry chain, plus iterative unsigned MUL and DIV.
module alu_6502_wide #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RDY,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             right,
   input  logic [WIDTH-1:0] AI,
   input  logic [WIDTH-1:0] BI,
   input  logic             CI,
   input  logic             BCD,
   output logic [WIDTH-1:0] OUT,
   output logic [WIDTH-1:0] HI,
   output logic             CO,
   output logic             HC,
   output logic             N,
   output logic             V,
   output logic             Z,
   output logic             busy,
   output logic             done
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(WIDTH + 1);

   typedef enum logic {S_IDLE, S_ITER} state_t;

   state_t           state_reg;
   logic [CW-1:0]    count_reg;
   logic             md_div_reg;
   logic [WIDTH-1:0] md_b_reg;
   logic [WIDTH-1:0] md_hi_reg;
   logic [WIDTH-1:0] md_lo_reg;
   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] hi_reg;
   logic             co_reg;
   logic             hc_reg;
   logic             n_reg;
   logic             a_msb_reg;
   logic             b_msb_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [3:0]       op_eff;
   logic             is_mul;
   logic             is_div;
   logic [WIDTH:0]   logic_res;
   logic [WIDTH-1:0] b_opnd;
   logic             cin;
   logic [NIB:0]     carry;
   logic [NIB-1:0][4:0] nsum;
   logic [WIDTH-1:0] sum_bin;

   always_comb begin
      case (op)
         4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1011,
         4'b1100, 4'b1101, 4'b1110, 4'b1111: op_eff = op;
         default:                             op_eff = 4'b1111;
      endcase
   end

   assign is_mul = (op_eff == 4'b0000);
   assign is_div = (op_eff == 4'b0001);

   always_comb begin
      logic_res = '0;
      case (op_eff[1:0])
         2'b00:   logic_res = {1'b0, AI | BI};
         2'b01:   logic_res = {1'b0, AI & BI};
         2'b10:   logic_res = {1'b0, AI ^ BI};
         default: logic_res = {1'b0, AI};
      endcase
      // The bit shifted out lands above the datapath so the adder carries it into CO.
      if (right)
         logic_res = {AI[0], CI, AI[WIDTH-1:1]};
   end

   always_comb begin
      case (op_eff[3:2])
         2'b00:   b_opnd = BI;
         2'b01:   b_opnd = ~BI;
         2'b10:   b_opnd = logic_res[WIDTH-1:0];
         default: b_opnd = '0;
      endcase
   end

   assign cin      = (right || op_eff[3:2] == 2'b11) ? 1'b0 : CI;
   assign carry[0] = cin;

   for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      logic ext;
      if (gi == NIB - 1) begin : g_top
         assign ext = logic_res[WIDTH];
      end else begin : g_low
         assign ext = 1'b0;
      end
      assign nsum[gi] = {ext, logic_res[4*gi +: 4]} + {1'b0, b_opnd[4*gi +: 4]} + {4'b0, carry[gi]};
      assign carry[gi+1] = nsum[gi][4] | (BCD & (nsum[gi][3:1] >= 3'd5));
      assign sum_bin[4*gi +: 4] = nsum[gi][3:0];
   end

   // One shift-add multiply step and one restoring divide step.
   logic             mul_c;
   logic [WIDTH-1:0] mul_sum;
   logic [WIDTH-1:0] mul_hi_next;
   logic [WIDTH-1:0] mul_lo_next;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] div_hi_next;
   logic [WIDTH-1:0] div_lo_next;
   logic             fin_co;
   logic             fin_n;

   assign {mul_c, mul_sum} = {1'b0, md_hi_reg} + (md_lo_reg[0] ? {1'b0, md_b_reg} : '0);
   assign mul_hi_next      = {mul_c, mul_sum[WIDTH-1:1]};
   assign mul_lo_next      = {mul_sum[0], md_lo_reg[WIDTH-1:1]};

   assign rem_sh      = {md_hi_reg, md_lo_reg[WIDTH-1]};
   assign diff        = rem_sh - {1'b0, md_b_reg};
   assign ge          = ~diff[WIDTH];
   assign div_hi_next = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign div_lo_next = {md_lo_reg[WIDTH-2:0], ge};

   assign fin_co = md_div_reg ? 1'b0 : |md_hi_reg;
   assign fin_n  = md_lo_reg[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         count_reg  <= '0;
         md_div_reg <= 1'b0;
         md_b_reg   <= '0;
         md_hi_reg  <= '0;
         md_lo_reg  <= '0;
         out_reg    <= '0;
         hi_reg     <= '0;
         co_reg     <= 1'b0;
         hc_reg     <= 1'b0;
         n_reg      <= 1'b0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else if (RDY) begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  if ((is_mul || is_div) && BI != '0) begin
                     md_div_reg <= is_div;
                     md_b_reg   <= BI;
                     md_hi_reg  <= '0;
                     md_lo_reg  <= AI;
                     count_reg  <= '0;
                     busy_reg   <= 1'b1;
                     state_reg  <= S_ITER;
                  end else if (is_div) begin
                     out_reg   <= '1;
                     hi_reg    <= AI;
                     co_reg    <= 1'b1;
                     hc_reg    <= 1'b0;
                     n_reg     <= 1'b1;
                     a_msb_reg <= 1'b0;
                     b_msb_reg <= 1'b0;
                     done_reg  <= 1'b1;
                  end else if (is_mul) begin
                     out_reg   <= '0;
                     hi_reg    <= '0;
                     co_reg    <= 1'b0;
                     hc_reg    <= 1'b0;
                     n_reg     <= 1'b0;
                     a_msb_reg <= 1'b0;
                     b_msb_reg <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     out_reg   <= sum_bin;
                     hi_reg    <= '0;
                     co_reg    <= carry[NIB];
                     hc_reg    <= carry[1];
                     n_reg     <= sum_bin[WIDTH-1];
                     a_msb_reg <= AI[WIDTH-1];
                     b_msb_reg <= b_opnd[WIDTH-1];
                     done_reg  <= 1'b1;
                  end
               end
            end
            default: begin
               if (count_reg == CW'(WIDTH)) begin
                  // a_msb absorbs CO^N so that V reads 0 for MUL/DIV.
                  out_reg   <= md_lo_reg;
                  hi_reg    <= md_hi_reg;
                  co_reg    <= fin_co;
                  hc_reg    <= 1'b0;
                  n_reg     <= fin_n;
                  a_msb_reg <= fin_co ^ fin_n;
                  b_msb_reg <= 1'b0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= S_IDLE;
               end else begin
                  md_hi_reg <= md_div_reg ? div_hi_next : mul_hi_next;
                  md_lo_reg <= md_div_reg ? div_lo_next : mul_lo_next;
                  count_reg <= count_reg + 1'b1;
               end
            end
         endcase
      end
   end

   assign OUT  = out_reg;
   assign HI   = hi_reg;
   assign CO   = co_reg;
   assign HC   = hc_reg;
   assign N    = n_reg;
   assign V    = a_msb_reg ^ b_msb_reg ^ co_reg ^ n_reg;
   assign Z    = ~|out_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule
